// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the three-requester memory arbiter: FSM encoding,
// requester IDs and default widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 255;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    function automatic logic [1:0] nextId(input logic [1:0] id);
        return (id == STORE) ? FETCH : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters, highest priority
// at the pointer position.
module rr_pick3
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] id
);

    logic [1:0] c0, c1, c2;

    always_comb begin
        c0 = ptr;
        c1 = nextId(c0);
        c2 = nextId(c1);
        valid = 1'b0;
        id    = FETCH;
        // Later matches overwrite earlier ones, so c0 ends up with top priority.
        if (req[c2]) begin valid = 1'b1; id = c2; end
        if (req[c1]) begin valid = 1'b1; id = c1; end
        if (req[c0]) begin valid = 1'b1; id = c0; end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for fetch, load and store units with a
// WAIT-state timeout and suppression of completions for withdrawn requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memDone,
    input  logic [DATA_W-1:0] memRdata
);

    logic [1:0]        state;
    logic [1:0]        ptr;
    logic [1:0]        id;
    logic              justDone;
    logic              dropped;
    logic              weQ;
    logic              errQ;
    logic [7:0]        waitCnt;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;

    logic [2:0]        reqM;
    logic              pickVld;
    logic [1:0]        pickId;
    logic [ADDR_W-1:0] addrSel;
    logic              doneFire;

    // The unit just served sits out the following IDLE cycle.
    always_comb begin
        reqM = req;
        if (justDone) reqM[id] = 1'b0;
    end

    rr_pick3 uPick (
        .req   (reqM),
        .ptr   (ptr),
        .valid (pickVld),
        .id    (pickId)
    );

    always_comb begin
        addrSel = addr0;
        case (pickId)
            LOAD:    addrSel = addr1;
            STORE:   addrSel = addr2;
            default: addrSel = addr0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= FETCH;
            id       <= FETCH;
            justDone <= 1'b0;
            dropped  <= 1'b0;
            weQ      <= 1'b0;
            errQ     <= 1'b0;
            waitCnt  <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            rdataQ   <= '0;
        end else begin
            justDone <= 1'b0;
            case (state)
                S_IDLE: if (pickVld) begin
                    id      <= pickId;
                    addrQ   <= addrSel;
                    weQ     <= (pickId == STORE);
                    wdataQ  <= wdata2;
                    dropped <= 1'b0;
                    errQ    <= 1'b0;
                    rdataQ  <= '0;
                    waitCnt <= '0;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!req[id]) dropped <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!req[id]) dropped <= 1'b1;
                    // A completion in the expiry cycle takes precedence over the timeout.
                    if (memDone) begin
                        rdataQ  <= weQ ? '0 : memRdata;
                        waitCnt <= '0;
                        state   <= S_RESP;
                    end else if (waitCnt == 8'(TIMEOUT - 1)) begin
                        errQ    <= 1'b1;
                        waitCnt <= '0;
                        state   <= S_RESP;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    ptr      <= nextId(id);
                    justDone <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign doneFire = (state == S_RESP) && !dropped;
    assign done     = doneFire ? (3'b001 << id) : 3'b000;
    assign err      = doneFire && errQ;
    assign rdata    = doneFire ? rdataQ : '0;
    assign memEn    = (state == S_ISSUE);
    assign memWe    = memEn && weQ;
    assign memAddr  = addrQ;
    assign memWdata = wdataQ;

endmodule
